// File: rtl/traffic_light_monitor.sv
// Passive run-time checker for the traffic light controller: decodes lamps to phase,
// times each phase against nominal lengths and checks the G1-N1-G2-N2-G3-Y-R order.
module traffic_light_monitor #(
    parameter int unsigned T_G1 = 1024,
    parameter int unsigned T_N  = 128,
    parameter int unsigned T_G  = 128,
    parameter int unsigned T_Y  = 512,
    parameter int unsigned T_R  = 1024,
    parameter int unsigned TOL  = 1,
    parameter int unsigned CW   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pass,
    input  logic        R,
    input  logic        G,
    input  logic        Y,
    output logic [2:0]  phase,
    output logic        err,
    output logic [2:0]  err_code,
    output logic        err_pulse,
    output logic [7:0]  err_cnt,
    output logic        cycle_done,
    output logic [15:0] cycle_cnt
);

    typedef enum logic [2:0] {
        PH_G1     = 3'd0,
        PH_N1     = 3'd1,
        PH_G2     = 3'd2,
        PH_N2     = 3'd3,
        PH_G3     = 3'd4,
        PH_Y      = 3'd5,
        PH_R      = 3'd6,
        PH_RESYNC = 3'd7
    } phase_t;

    // Lamp patterns in {R,G,Y} order
    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_Y   = 3'b001;
    localparam logic [2:0] LAMP_G   = 3'b010;
    localparam logic [2:0] LAMP_R   = 3'b100;

    localparam logic [2:0] E_NONE    = 3'd0;
    localparam logic [2:0] E_ILLEGAL = 3'd1;
    localparam logic [2:0] E_SEQ     = 3'd2;
    localparam logic [2:0] E_SHORT   = 3'd3;
    localparam logic [2:0] E_LONG    = 3'd4;

    localparam logic [CW-1:0] RUN_MAX = '1;

    function automatic logic [CW-1:0] nom_len(input phase_t p);
        case (p)
            PH_G1:        nom_len = CW'(T_G1);
            PH_N1, PH_N2: nom_len = CW'(T_N);
            PH_G2, PH_G3: nom_len = CW'(T_G);
            PH_Y:         nom_len = CW'(T_Y);
            default:      nom_len = CW'(T_R);
        endcase
    endfunction

    function automatic phase_t next_ph(input phase_t p);
        case (p)
            PH_G1:   next_ph = PH_N1;
            PH_N1:   next_ph = PH_G2;
            PH_G2:   next_ph = PH_N2;
            PH_N2:   next_ph = PH_G3;
            PH_G3:   next_ph = PH_Y;
            PH_Y:    next_ph = PH_R;
            PH_R:    next_ph = PH_G1;
            default: next_ph = PH_RESYNC;
        endcase
    endfunction

    function automatic logic [2:0] ph_lamp(input phase_t p);
        case (p)
            PH_G1, PH_G2, PH_G3: ph_lamp = LAMP_G;
            PH_Y:                ph_lamp = LAMP_Y;
            PH_R:                ph_lamp = LAMP_R;
            default:             ph_lamp = LAMP_OFF;
        endcase
    endfunction

    logic [2:0]    lamp_q, lamp_prev;
    logic          pass_q, pass_seen, long_flag, waive, cyc_err;
    logic [CW-1:0] run_cnt;
    phase_t        phase_q;

    phase_t        phase_d;
    logic [CW-1:0] run_d, len_min, len_over;
    logic          pass_seen_d, long_d, waive_d, cyc_err_d, done_d;
    logic          transition, illegal, checked;
    logic [2:0]    code;

    // Next-state: phase tracking, length checks and error prioritisation
    always_comb begin
        phase_d     = phase_q;
        run_d       = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + CW'(1);
        pass_seen_d = pass_seen | pass_q;
        long_d      = long_flag;
        waive_d     = waive;
        cyc_err_d   = cyc_err;
        done_d      = 1'b0;
        code        = E_NONE;

        transition = (lamp_q != lamp_prev);
        illegal    = (lamp_q[2] & lamp_q[1]) | (lamp_q[2] & lamp_q[0]) | (lamp_q[1] & lamp_q[0]);
        checked    = (phase_q != PH_RESYNC) && !((phase_q == PH_G1) && waive);
        len_min    = nom_len(phase_q) - CW'(TOL);
        len_over   = nom_len(phase_q) + CW'(TOL + 1);

        if (transition) begin
            run_d  = CW'(1);
            long_d = 1'b0;
            if (illegal) begin
                code    = E_ILLEGAL;
                phase_d = PH_RESYNC;
            end else if (pass_seen && (lamp_q == LAMP_G)) begin
                phase_d = PH_G1;
                waive_d = 1'b1;
            end else if (phase_q == PH_RESYNC) begin
                if ((lamp_prev == LAMP_R) && (lamp_q == LAMP_G)) begin
                    phase_d = PH_G1;
                    waive_d = 1'b0;
                end
            end else begin
                if (checked && !long_flag && (run_cnt < len_min)) begin
                    code = E_SHORT;
                end
                if (lamp_q != ph_lamp(next_ph(phase_q))) begin
                    code    = E_SEQ;
                    phase_d = PH_RESYNC;
                end else begin
                    phase_d = next_ph(phase_q);
                    if (phase_q == PH_G1) begin
                        pass_seen_d = 1'b0;
                        waive_d     = 1'b0;
                    end
                    done_d = (phase_q == PH_R) && (code == E_NONE) && !cyc_err;
                end
            end
        end else if (checked && !long_flag && (run_cnt == len_over)) begin
            code   = E_LONG;
            long_d = 1'b1;
        end

        if (code != E_NONE) begin
            cyc_err_d = 1'b1;
        end
        // A fresh G1 entry starts a new clean-cycle window
        if ((phase_d == PH_G1) && (phase_q != PH_G1)) begin
            cyc_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lamp_q     <= LAMP_G;
            lamp_prev  <= LAMP_G;
            pass_q     <= 1'b0;
            run_cnt    <= '0;
            pass_seen  <= 1'b0;
            long_flag  <= 1'b0;
            waive      <= 1'b0;
            cyc_err    <= 1'b0;
            phase_q    <= PH_G1;
            err        <= 1'b0;
            err_code   <= E_NONE;
            err_pulse  <= 1'b0;
            err_cnt    <= '0;
            cycle_done <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            lamp_q     <= {R, G, Y};
            lamp_prev  <= lamp_q;
            pass_q     <= pass;
            run_cnt    <= run_d;
            pass_seen  <= pass_seen_d;
            long_flag  <= long_d;
            waive      <= waive_d;
            cyc_err    <= cyc_err_d;
            phase_q    <= phase_d;
            err_pulse  <= (code != E_NONE);
            cycle_done <= done_d;
            if (code != E_NONE) begin
                err <= 1'b1;
                if (!err) begin
                    err_code <= code;
                end
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
            if (done_d && (cycle_cnt != 16'hFFFF)) begin
                cycle_cnt <= cycle_cnt + 16'd1;
            end
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: each stimulus run queues the phase change,
// error pulse and cycle_done it should cause, and the monitor matches value and arrival edge.
module tb_traffic_light_monitor;

    localparam logic [2:0] L_OFF = 3'b000;
    localparam logic [2:0] L_Y   = 3'b001;
    localparam logic [2:0] L_G   = 3'b010;
    localparam logic [2:0] L_R   = 3'b100;
    localparam logic [2:0] L_RG  = 3'b110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pass = 1'b0;
    logic        R = 1'b0, G = 1'b1, Y = 1'b0;
    logic [2:0]  phase;
    logic        err;
    logic [2:0]  err_code;
    logic        err_pulse;
    logic [7:0]  err_cnt;
    logic        cycle_done;
    logic [15:0] cycle_cnt;

    traffic_light_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .pass       (pass),
        .R          (R),
        .G          (G),
        .Y          (Y),
        .phase      (phase),
        .err        (err),
        .err_code   (err_code),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt),
        .cycle_done (cycle_done),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int at;
    } exp_t;

    exp_t q_ph[$];
    exp_t q_err[$];
    exp_t q_cd[$];

    int   edge_no    = 0;
    logic rst_q      = 1'b1;
    int   last_phase = 0;
    int   n_checks   = 0;
    int   n_fail     = 0;

    always @(posedge clk) begin
        edge_no <= edge_no + 1;
        rst_q   <= rst;
    end

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, edge_no);
        end
    endtask

    task automatic monitor_step();
        exp_t e;
        if (rst_q) begin
            last_phase = int'(phase);
            return;
        end
        if (int'(phase) != last_phase) begin
            if (q_ph.size() == 0) begin
                check_val("phase_unexpected", int'(phase), last_phase);
            end else begin
                e = q_ph.pop_front();
                check_val("phase", int'(phase), e.val);
                check_val("phase_edge", edge_no, e.at);
            end
            last_phase = int'(phase);
        end
        if (err_pulse) begin
            if (q_err.size() == 0) begin
                check_val("err_pulse_unexpected", int'(err_pulse), 0);
            end else begin
                e = q_err.pop_front();
                check_val("err_code", int'(err_code), e.val);
                check_val("err_edge", edge_no, e.at);
            end
        end
        if (cycle_done) begin
            if (q_cd.size() == 0) begin
                check_val("cycle_done_unexpected", int'(cycle_done), 0);
            end else begin
                e = q_cd.pop_front();
                check_val("cycle_cnt", int'(cycle_cnt), e.val);
                check_val("cycle_done_edge", edge_no, e.at);
            end
        end
    endtask

    always @(negedge clk) monitor_step();

    // Apply a lamp pattern for n samples; queue what the monitor must report for it
    task automatic drive(input logic [2:0] pat, input int n, input int ph,
                         input int ecode = 0, input int eoff = 1,
                         input int cd = 0, input logic p = 1'b0);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (ph >= 0) begin
                    e.val = ph; e.at = edge_no + 2;
                    q_ph.push_back(e);
                end
                if (ecode != 0) begin
                    e.val = ecode; e.at = edge_no + 1 + eoff;
                    q_err.push_back(e);
                end
                if (cd != 0) begin
                    e.val = cd; e.at = edge_no + 2;
                    q_cd.push_back(e);
                end
            end
            rst = 1'b0;
            {R, G, Y} = pat;
            pass = p;
        end
    endtask

    task automatic do_reset(input logic [2:0] pat);
        @(negedge clk);
        rst = 1'b1;
        {R, G, Y} = pat;
        pass = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        check_val("rst_phase", int'(phase), 0);
        check_val("rst_err", int'(err), 0);
        check_val("rst_err_code", int'(err_code), 0);
        check_val("rst_err_pulse", int'(err_pulse), 0);
        check_val("rst_err_cnt", int'(err_cnt), 0);
        check_val("rst_cycle_done", int'(cycle_done), 0);
        check_val("rst_cycle_cnt", int'(cycle_cnt), 0);
    endtask

    task automatic end_scn(input string tag, input int ph, input int e,
                           input int ecode, input int ecnt, input int ccnt);
        repeat (3) @(negedge clk);
        check_val({tag, "_ph_left"}, q_ph.size(), 0);
        check_val({tag, "_err_left"}, q_err.size(), 0);
        check_val({tag, "_cd_left"}, q_cd.size(), 0);
        check_val({tag, "_phase"}, int'(phase), ph);
        check_val({tag, "_err"}, int'(err), e);
        check_val({tag, "_err_code"}, int'(err_code), ecode);
        check_val({tag, "_err_cnt"}, int'(err_cnt), ecnt);
        check_val({tag, "_cycle_cnt"}, int'(cycle_cnt), ccnt);
    endtask

    // G1 (first after reset) through G3, with the lamp pattern held at reset counted in G1
    task automatic front_half();
        drive(L_G, 1025, -1);
        drive(L_OFF, 128, 1);
        drive(L_G, 128, 2);
        drive(L_OFF, 128, 3);
        drive(L_G, 128, 4);
    endtask

    initial begin
        // Nominal cycle; N2 at T-TOL and G3 at T+TOL are still clean
        do_reset(L_G);
        drive(L_G, 1025, -1);
        drive(L_OFF, 128, 1);
        drive(L_G, 128, 2);
        drive(L_OFF, 127, 3);
        drive(L_G, 129, 4);
        drive(L_Y, 512, 5);
        drive(L_R, 1024, 6);
        drive(L_G, 10, 0, 0, 1, 1);
        check_val("nom_cycle_cnt", int'(cycle_cnt), 1);
        check_val("nom_err", int'(err), 0);
        check_val("nom_ph_left", q_ph.size(), 0);

        // Overlong yellow: error at run count 514, sequence carries on, no cycle_done
        drive(L_G, 1014, -1);
        drive(L_OFF, 128, 1);
        drive(L_G, 128, 2);
        drive(L_OFF, 128, 3);
        drive(L_G, 128, 4);
        drive(L_Y, 600, 5, 4, 515);
        drive(L_R, 1024, 6);
        drive(L_G, 200, 0);
        end_scn("long", 0, 1, 4, 1, 1);

        // Illegal lamp during G2, RESYNC until an R->G edge
        do_reset(L_G);
        drive(L_G, 1025, -1);
        drive(L_OFF, 128, 1);
        drive(L_G, 60, 2);
        drive(L_RG, 1, 7, 1, 1);
        drive(L_G, 60, -1);
        drive(L_OFF, 128, -1);
        drive(L_G, 128, -1);
        drive(L_Y, 512, -1);
        drive(L_R, 1024, -1);
        drive(L_G, 1024, 0);
        drive(L_OFF, 128, 1);
        drive(L_G, 10, 2);
        end_scn("illegal", 2, 1, 1, 1, 0);

        // pass interrupts Y; waived G1 of any length, then checks resume
        do_reset(L_G);
        front_half();
        drive(L_Y, 100, 5);
        drive(L_Y, 2, -1, 0, 1, 0, 1'b1);
        drive(L_G, 2990, 0, 0, 1, 0, 1'b1);
        drive(L_G, 10, -1);
        drive(L_OFF, 128, 1);
        drive(L_G, 128, 2);
        end_scn("pass", 2, 0, 0, 0, 0);

        // Short N1
        do_reset(L_G);
        drive(L_G, 1025, -1);
        drive(L_OFF, 60, 1);
        drive(L_G, 128, 2, 3, 1);
        end_scn("short", 2, 1, 3, 1, 0);

        // G1 straight to Y, then reset mid-Y and run a clean cycle
        do_reset(L_G);
        drive(L_G, 1025, -1);
        drive(L_Y, 300, 7, 2, 1);
        end_scn("seq", 7, 1, 2, 1, 0);
        do_reset(L_Y);
        front_half();
        drive(L_Y, 512, 5);
        drive(L_R, 1024, 6);
        drive(L_G, 20, 0, 0, 1, 1);
        end_scn("post_rst", 0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
